spi_rx_word_queue: RTL and testbench

// - Receive-side word queue directly downstream of the SPI slave/master core receive port.
// - Captures each received word offered by a one-cycle request pulse and returns a one-cycle done pulse.
// - Buffers words in a DEPTH-entry circular FIFO and presents them show-ahead (valid/ready) to the

---
 rtl/spi_rx_word_queue.sv | 156 +++++++++++++++
 tb/tb_spi_rx_word_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_word_queue.sv
// rtl/spi_rx_word_queue.sv - SPI receive word FIFO with registered show-ahead head word and drop counter
// Optional almost_full output enabled by defining SPI_RXQ_AFULL_EN.
module spi_rx_word_queue #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_request,
  output logic                       in_done,
  output logic                       in_overflow,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [7:0]                 drop_cnt,
  output logic                       almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {ST_EMPTY, ST_HEAD} state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              in_done_q, in_done_d;
  logic              in_overflow_q, in_overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              pop;
  logic              accept;
  logic              drop;
  logic              full_now;
  logic [PW-1:0]     rd_next;

  assign full_now = (count_q == CW'(DEPTH));
  assign pop      = (state_q == ST_HEAD) && out_ready;
  assign accept   = in_request && (!full_now || pop);
  assign drop     = in_request && full_now && !pop;
  assign rd_next  = rd_ptr_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    out_data_d    = out_data_q;
    in_done_d     = 1'b0;
    in_overflow_d = 1'b0;
    drop_cnt_d    = drop_cnt_q;

    if (flush) begin
      state_d    = ST_EMPTY;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      out_data_d = '0;
    end else begin
      in_done_d     = accept;
      in_overflow_d = drop;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_next;

      case ({accept, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      // Head register mirrors mem[rd_ptr]; the word behind it is already in memory when count >= 2.
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_data_d = in_data;
            state_d    = ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (pop) begin
            if (count_q == CW'(1)) begin
              if (accept) out_data_d = in_data;
              else        state_d    = ST_EMPTY;
            end else begin
              out_data_d = mem_q[rd_next];
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      out_data_q    <= '0;
      in_done_q     <= 1'b0;
      in_overflow_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      in_done_q     <= in_done_d;
      in_overflow_q <= in_overflow_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && accept) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_done     = in_done_q;
  assign in_overflow = in_overflow_q;
  assign out_data    = out_data_q;
  assign out_valid   = (state_q == ST_HEAD);
  assign count       = count_q;
  assign full        = full_now;
  assign empty       = (count_q == '0);
  assign drop_cnt    = drop_cnt_q;

`ifdef SPI_RXQ_AFULL_EN
  logic almost_full_q;

  always_ff @(posedge clk) begin
    if (rst) almost_full_q <= 1'b0;
    else     almost_full_q <= (count_d >= CW'(AFULL_LVL));
  end

  assign almost_full = almost_full_q;
`else
  if (AFULL_LVL < 0) begin : g_afull_lvl_ignored
  end

  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_word_queue.sv
// tb/tb_spi_rx_word_queue.sv - self-checking bench for spi_rx_word_queue
// Queue-based reference model checked every cycle, plus directed literal expectations.
module tb_spi_rx_word_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_request = 1'b0;
  logic        in_done;
  logic        in_overflow;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic [7:0]  drop_cnt;
  logic        almost_full;

  spi_rx_word_queue #(.DATA_W(16), .DEPTH(DEPTH), .AFULL_LVL(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_request(in_request),
    .in_done(in_done), .in_overflow(in_overflow),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty),
    .drop_cnt(drop_cnt), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored words plus pulse/counter state.
  logic [15:0] m_q[$];
  logic [15:0] m_popped[$];
  bit          m_done, m_ovf, m_started;
  int          m_drop;

  always @(posedge clk) begin
    bit pop, acc;
    pop = (m_q.size() > 0) && out_ready;
    if (rst) begin
      m_q.delete();
      m_done = 0; m_ovf = 0; m_drop = 0; m_started = 1;
    end else if (flush) begin
      m_q.delete();
      m_done = 0; m_ovf = 0;
    end else begin
      acc = in_request && ((m_q.size() < DEPTH) || pop);
      if (pop) m_popped.push_back(m_q.pop_front());
      if (acc) m_q.push_back(in_data);
      m_done = acc;
      m_ovf  = in_request && !acc;
      if (m_ovf && m_drop < 255) m_drop++;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("out_valid", out_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("out_data", out_data, m_q[0]);
      chk("count", count, m_q.size());
      chk("full", full, m_q.size() == DEPTH);
      chk("empty", empty, m_q.size() == 0);
      chk("in_done", in_done, m_done);
      chk("in_overflow", in_overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
`ifdef SPI_RXQ_AFULL_EN
      chk("almost_full", almost_full, m_q.size() >= 6);
`else
      chk("almost_full", almost_full, 1'b0);
`endif
    end
  end

  task automatic cyc(input bit req, input logic [15:0] d, input bit rdy, input bit fl);
    in_request = req; in_data = d; out_ready = rdy; flush = fl;
    @(posedge clk); #1;
    in_request = 0; out_ready = 0; flush = 0;
  endtask

  initial begin
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_drop", drop_cnt, 0);

    // single word
    cyc(1, 16'hA5A5, 0, 0);
    chk("a5_done", in_done, 1);
    chk("a5_data", out_data, 16'hA5A5);
    chk("a5_count", count, 1);
    cyc(0, 0, 0, 0);
    chk("a5_done_pulse", in_done, 0);
    cyc(0, 0, 1, 0);
    chk("a5_drained", empty, 1);

    // fill, overflow, full push+pop
    m_popped.delete();
    for (int i = 1; i <= 8; i++) cyc(1, 16'(i), 0, 0);
    chk("fill_full", full, 1);
    cyc(1, 16'h00FF, 0, 0);
    chk("ovf_pulse", in_overflow, 1);
    chk("ovf_done", in_done, 0);
    chk("ovf_drop", drop_cnt, 1);
    cyc(1, 16'h0009, 1, 0);
    chk("fullpp_done", in_done, 1);
    chk("fullpp_ovf", in_overflow, 0);
    chk("fullpp_count", count, 8);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0);
    chk("fill_log_len", m_popped.size(), 9);
    for (int i = 0; i < 9 && i < m_popped.size(); i++) chk("fill_log", m_popped[i], 16'(i + 1));

    // continuous streaming with pointer wrap
    m_popped.delete();
    cyc(1, 16'h0100, 0, 0);
    for (int i = 1; i < 20; i++) begin
      cyc(1, 16'h0100 + 16'(i), 1, 0);
      chk("stream_valid", out_valid, 1);
      chk("stream_count", count, 1);
    end
    cyc(0, 0, 1, 0);
    chk("stream_log_len", m_popped.size(), 20);
    for (int i = 0; i < 20 && i < m_popped.size(); i++) chk("stream_log", m_popped[i], 16'h0100 + 16'(i));

    // flush with a coincident request
    for (int i = 0; i < 3; i++) cyc(1, 16'h00C1 + 16'(i), 0, 0);
    chk("pre_flush_count", count, 3);
    m_popped.delete();
    cyc(1, 16'hBEEF, 0, 1);
    chk("flush_empty", empty, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_done", in_done, 0);
    chk("flush_ovf", in_overflow, 0);
    chk("flush_drop", drop_cnt, 1);
    repeat (3) cyc(0, 0, 1, 0);
    chk("flush_no_beef", m_popped.size(), 0);

    // fill with almost_full tracking, then saturate drop counter
    for (int i = 0; i < 8; i++) begin
      cyc(1, 16'h00D0 + 16'(i), 0, 0);
`ifdef SPI_RXQ_AFULL_EN
      chk("af_rise", almost_full, (i + 1) >= 6);
`else
      chk("af_tied", almost_full, 0);
`endif
    end
    for (int i = 0; i < 300; i++) cyc(1, 16'hEEEE, 0, 0);
    chk("drop_sat", drop_cnt, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0);
`ifdef SPI_RXQ_AFULL_EN
      chk("af_fall", almost_full, (7 - i) >= 6);
`endif
    end

    // reset with a request pending
    cyc(1, 16'h1234, 0, 0);
    rst = 1;
    cyc(1, 16'h5678, 0, 0);
    rst = 0;
    chk("midrst_done", in_done, 0);
    chk("midrst_count", count, 0);
    chk("midrst_drop", drop_cnt, 0);
    repeat (2) cyc(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
